// File: rtl/mdio_responder.sv
// PHY-side Clause 22 MDIO management responder.
// MDC/MDIO are oversampled on Clk. It holds a 32x16 register file and reports writes to local logic.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0007,
  parameter logic [15:0] PHY_ID2  = 16'hC0F1,
  parameter logic [15:0] REG0_DEF = 16'h3100
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MDC,
  input  logic        MDIO_I,
  output logic        MDIO_O,
  output logic        MDIO_Oe,
  input  logic [15:0] Status_In,
  output logic [15:0] Reg0_Ctrl,
  output logic        Wr_Strb,
  output logic [4:0]  Wr_Addr,
  output logic [15:0] Wr_Data,
  output logic        Rd_Strb,
  output logic        Busy,
  output logic        Frame_Err
);

  typedef enum logic [2:0] {HUNT, ST2, OP, PHYAD, REGAD, TA, DATA, SKIP} state_t;

  // Bit 15 of register 0 is self-clearing, so it is never stored.
  localparam logic [15:0] REG0_RST = REG0_DEF & 16'h7FFF;

  logic [2:0]  mdc_sync_q;
  logic [1:0]  mdio_sync_q;
  state_t      state_q, state_d;
  logic [5:0]  ones_q, ones_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_read_q, is_read_d;
  logic        match_q, match_d;
  logic        wr_bad_q, wr_bad_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] rd_sr_q, rd_sr_d;
  logic        oe_q, oe_d;
  logic        o_q, o_d;
  logic        busy_q, busy_d;
  logic        ferr_q, ferr_d;
  logic        rd_strb_q, rd_strb_d;
  logic        commit_q, commit_d;
  logic        wr_strb_q, wr_strb_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] reg0_q, reg0_d;
  logic [15:0] regfile_q [4:31];
  logic [15:0] regfile_d [4:31];

  logic        bit_evt;
  logic        bit_val;
  logic [4:0]  reg_sel;
  logic [15:0] rd_mux;
  logic        clear_all;

  assign bit_evt   = mdc_sync_q[1] & ~mdc_sync_q[2];
  assign bit_val   = mdio_sync_q[1];
  assign reg_sel   = {shift_q[3:0], bit_val};
  assign clear_all = commit_q && (regad_q == 5'd0) && shift_q[15];

  always_comb begin
    rd_mux = 16'h0000;
    case (reg_sel)
      5'd0:    rd_mux = reg0_q;
      5'd1:    rd_mux = Status_In;
      5'd2:    rd_mux = PHY_ID1;
      5'd3:    rd_mux = PHY_ID2;
      default: begin
        for (int i = 4; i < 32; i++) begin
          if (reg_sel == i[4:0]) rd_mux = regfile_q[i];
        end
      end
    endcase
  end

  // Frame decoder; cnt_q is the index of the current bit counted from the first ST bit.
  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    cnt_d     = cnt_q;
    is_read_d = is_read_q;
    match_d   = match_q;
    wr_bad_d  = wr_bad_q;
    shift_d   = shift_q;
    regad_d   = regad_q;
    rd_sr_d   = rd_sr_q;
    oe_d      = oe_q;
    o_d       = o_q;
    busy_d    = busy_q;
    ferr_d    = 1'b0;
    rd_strb_d = 1'b0;
    commit_d  = 1'b0;
    if (bit_evt) begin
      if (state_q != HUNT) cnt_d = cnt_q + 5'd1;
      case (state_q)
        HUNT: begin
          if (bit_val) begin
            if (ones_q != 6'd32) ones_d = ones_q + 6'd1;
          end else if (ones_q == 6'd32) begin
            state_d = ST2;
            cnt_d   = 5'd1;
            ones_d  = 6'd0;
          end else begin
            ones_d = 6'd0;
          end
        end
        ST2: begin
          if (bit_val) begin
            state_d = OP;
            busy_d  = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            state_d = HUNT;
            cnt_d   = 5'd0;
          end
        end
        OP: begin
          if (cnt_q == 5'd2) begin
            is_read_d = bit_val;
          end else if (is_read_q != bit_val) begin
            state_d  = PHYAD;
            wr_bad_d = 1'b0;
          end else begin
            ferr_d  = 1'b1;
            state_d = SKIP;
          end
        end
        PHYAD: begin
          shift_d = {shift_q[14:0], bit_val};
          if (cnt_q == 5'd8) begin
            match_d = (reg_sel == PHY_ADDR);
            state_d = REGAD;
          end
        end
        REGAD: begin
          shift_d = {shift_q[14:0], bit_val};
          if (cnt_q == 5'd13) begin
            regad_d = reg_sel;
            rd_sr_d = rd_mux;
            state_d = match_q ? TA : SKIP;
          end
        end
        TA: begin
          if (is_read_q) begin
            if (cnt_q == 5'd14) begin
              oe_d = 1'b1;
              o_d  = 1'b0;
            end else begin
              o_d     = rd_sr_q[15];
              rd_sr_d = {rd_sr_q[14:0], 1'b0};
            end
          end else if ((cnt_q == 5'd14) != bit_val) begin
            wr_bad_d = 1'b1;
          end
          if (cnt_q == 5'd15) state_d = DATA;
        end
        DATA: begin
          shift_d = {shift_q[14:0], bit_val};
          if (is_read_q) begin
            o_d     = rd_sr_q[15];
            rd_sr_d = {rd_sr_q[14:0], 1'b0};
          end
        end
        default: ;
      endcase
      if ((state_q == DATA || state_q == SKIP) && cnt_q == 5'd31) begin
        state_d = HUNT;
        busy_d  = 1'b0;
        ones_d  = 6'd0;
        cnt_d   = 5'd0;
        oe_d    = 1'b0;
        o_d     = 1'b0;
        if (state_q == DATA) begin
          if (is_read_q)     rd_strb_d = 1'b1;
          else if (wr_bad_q) ferr_d    = 1'b1;
          else               commit_d  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wr_strb_d = commit_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    reg0_d    = reg0_q;
    if (commit_q) begin
      wr_addr_d = regad_q;
      wr_data_d = shift_q;
      if (regad_q == 5'd0) reg0_d = shift_q[15] ? REG0_RST : {1'b0, shift_q[14:0]};
    end
  end

  always_comb begin
    for (int i = 4; i < 32; i++) begin
      regfile_d[i] = regfile_q[i];
      if (clear_all)                            regfile_d[i] = 16'h0000;
      else if (commit_q && regad_q == i[4:0])   regfile_d[i] = shift_q;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
      state_q     <= HUNT;
      ones_q      <= '0;
      cnt_q       <= '0;
      is_read_q   <= 1'b0;
      match_q     <= 1'b0;
      wr_bad_q    <= 1'b0;
      shift_q     <= '0;
      regad_q     <= '0;
      rd_sr_q     <= '0;
      oe_q        <= 1'b0;
      o_q         <= 1'b0;
      busy_q      <= 1'b0;
      ferr_q      <= 1'b0;
      rd_strb_q   <= 1'b0;
      commit_q    <= 1'b0;
      wr_strb_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      reg0_q      <= REG0_RST;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[1:0], MDC};
      mdio_sync_q <= {mdio_sync_q[0], MDIO_I};
      state_q     <= state_d;
      ones_q      <= ones_d;
      cnt_q       <= cnt_d;
      is_read_q   <= is_read_d;
      match_q     <= match_d;
      wr_bad_q    <= wr_bad_d;
      shift_q     <= shift_d;
      regad_q     <= regad_d;
      rd_sr_q     <= rd_sr_d;
      oe_q        <= oe_d;
      o_q         <= o_d;
      busy_q      <= busy_d;
      ferr_q      <= ferr_d;
      rd_strb_q   <= rd_strb_d;
      commit_q    <= commit_d;
      wr_strb_q   <= wr_strb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      reg0_q      <= reg0_d;
    end
  end

  genvar gi;
  generate
    for (gi = 4; gi < 32; gi++) begin : g_reg
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) regfile_q[gi] <= 16'h0000;
        else     regfile_q[gi] <= regfile_d[gi];
      end
    end
  endgenerate

  assign MDIO_O    = o_q;
  assign MDIO_Oe   = oe_q;
  assign Reg0_Ctrl = reg0_q;
  assign Wr_Strb   = wr_strb_q;
  assign Wr_Addr   = wr_addr_q;
  assign Wr_Data   = wr_data_q;
  assign Rd_Strb   = rd_strb_q;
  assign Busy      = busy_q;
  assign Frame_Err = ferr_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: a station model drives framed MDIO traffic with a pulled-up pad.
// It checks read data, drive windows and strobes against queued expectations.
module tb_mdio_responder;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        MDC = 1'b0;
  logic        station_oe = 1'b0;
  logic        station_val = 1'b1;
  logic [15:0] Status_In = 16'h0000;
  logic        MDIO_I, MDIO_O, MDIO_Oe;
  logic [15:0] Reg0_Ctrl, Wr_Data;
  logic [4:0]  Wr_Addr;
  logic        Wr_Strb, Rd_Strb, Busy, Frame_Err;

  int tests_run = 0;
  int tests_failed = 0;

  // Pad model: responder drive wins, then the station, else the pull-up.
  assign MDIO_I = MDIO_Oe ? MDIO_O : (station_oe ? station_val : 1'b1);

  always #5 Clk = ~Clk;

  mdio_responder dut (
    .Clk(Clk), .Rst(Rst), .MDC(MDC), .MDIO_I(MDIO_I), .MDIO_O(MDIO_O),
    .MDIO_Oe(MDIO_Oe), .Status_In(Status_In), .Reg0_Ctrl(Reg0_Ctrl),
    .Wr_Strb(Wr_Strb), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Rd_Strb(Rd_Strb),
    .Busy(Busy), .Frame_Err(Frame_Err)
  );

  int n_wr = 0, n_rd = 0, n_ferr = 0, n_busy = 0;
  logic busy_prev = 1'b0;
  logic [20:0] obs_wr[$];
  logic [20:0] exp_wr[$];
  logic [15:0] exp_rd[$];

  always @(negedge Clk) begin
    if (Wr_Strb) begin
      n_wr++;
      obs_wr.push_back({Wr_Addr, Wr_Data});
    end
    if (Rd_Strb) n_rd++;
    if (Frame_Err) n_ferr++;
    if (Busy && !busy_prev) n_busy++;
    busy_prev = Busy;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_bit(input logic drive, input logic val, output logic pad, output logic oe);
    station_oe  = drive;
    station_val = val;
    repeat (8) @(negedge Clk);
    pad = MDIO_I;
    oe  = MDIO_Oe;
    MDC = 1'b1;
    repeat (8) @(negedge Clk);
    MDC = 1'b0;
  endtask

  // One frame; abort_at >= 0 asserts Rst at that post-preamble bit instead of finishing.
  task automatic frame(input int npre, input logic [1:0] op, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd, input int abort_at,
                       output logic [15:0] rd, output int oe_cnt, output logic ta2);
    logic [31:0] fv;
    logic pad, oe, is_rd;
    fv = {2'b01, op, pa, ra, 2'b10, wd};
    is_rd = (op == 2'b10);
    rd = 16'h0000;
    oe_cnt = 0;
    ta2 = 1'b1;
    for (int i = 0; i < npre; i++) run_bit(1'b1, 1'b1, pad, oe);
    for (int i = 0; i < 32; i++) begin
      if (i == abort_at) begin
        check("abort_pre_oe", {31'd0, MDIO_Oe}, 32'd1);
        Rst = 1'b1;
        #1;
        check("abort_oe_drop", {31'd0, MDIO_Oe}, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        station_oe = 1'b0;
        return;
      end
      run_bit(!(is_rd && i >= 14), fv[31-i], pad, oe);
      if (oe) oe_cnt++;
      if (i == 15) ta2 = pad;
      if (i >= 16) rd[31-i] = pad;
    end
    run_bit(1'b1, 1'b0, pad, oe);
    station_oe = 1'b0;
  endtask

  task automatic run_check(input string tag, input int npre, input logic [1:0] op,
                           input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd,
                           input int e_oe, input int e_wr, input int e_rds, input int e_ferr,
                           input int e_busy, input bit chk_rd, input logic [15:0] e_rdv);
    int w0, r0, f0, b0, oe_cnt;
    logic [15:0] rd;
    logic ta2;
    logic [20:0] ew, ow;
    if (chk_rd) exp_rd.push_back(e_rdv);
    if (e_wr != 0) exp_wr.push_back({ra, wd});
    w0 = n_wr; r0 = n_rd; f0 = n_ferr; b0 = n_busy;
    frame(npre, op, pa, ra, wd, -1, rd, oe_cnt, ta2);
    check({tag, " oe_periods"}, oe_cnt, e_oe);
    check({tag, " wr_strobes"}, n_wr - w0, e_wr);
    check({tag, " rd_strobes"}, n_rd - r0, e_rds);
    check({tag, " frame_err"}, n_ferr - f0, e_ferr);
    check({tag, " busy_rises"}, n_busy - b0, e_busy);
    check({tag, " busy_end"}, {31'd0, Busy}, 32'd0);
    if (e_oe == 17) check({tag, " ta2"}, {31'd0, ta2}, 32'd0);
    if (chk_rd) check({tag, " rdata"}, rd, exp_rd.pop_front());
    if (e_wr != 0) begin
      ew = exp_wr.pop_front();
      if (obs_wr.size() == 0) begin
        check({tag, " wr_observed"}, 0, 1);
      end else begin
        ow = obs_wr.pop_front();
        check({tag, " wr_addr_data"}, ow, ew);
      end
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  pa;
    logic [4:0]  ra;
    logic [15:0] wd;
    logic [15:0] status;
    logic [15:0] exp_rd;
  } vec_t;

  localparam logic [1:0] RD = 2'b10;
  localparam logic [1:0] WR = 2'b01;

  initial begin
    vec_t vecs[18];
    logic [15:0] rd;
    int oe_cnt;
    logic ta2;
    bit is_rd, hit;

    vecs[0]  = '{WR, 5'd1, 5'd4, 16'hA5C3, 16'h0000, 16'h0000};
    vecs[1]  = '{RD, 5'd1, 5'd4, 16'h0000, 16'h0000, 16'hA5C3};
    vecs[2]  = '{RD, 5'd1, 5'd2, 16'h0000, 16'h0000, 16'h0007};
    vecs[3]  = '{RD, 5'd1, 5'd3, 16'h0000, 16'h0000, 16'hC0F1};
    vecs[4]  = '{RD, 5'd1, 5'd1, 16'h0000, 16'h782D, 16'h782D};
    vecs[5]  = '{RD, 5'd2, 5'd4, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[6]  = '{RD, 5'd1, 5'd0, 16'h0000, 16'h0000, 16'h3100};
    vecs[7]  = '{WR, 5'd1, 5'd4, 16'h1234, 16'h0000, 16'h0000};
    vecs[8]  = '{RD, 5'd1, 5'd4, 16'h0000, 16'h0000, 16'h1234};
    vecs[9]  = '{WR, 5'd1, 5'd0, 16'h8000, 16'h0000, 16'h0000};
    vecs[10] = '{RD, 5'd1, 5'd0, 16'h0000, 16'h0000, 16'h3100};
    vecs[11] = '{RD, 5'd1, 5'd4, 16'h0000, 16'h0000, 16'h0000};
    vecs[12] = '{WR, 5'd1, 5'd2, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[13] = '{RD, 5'd1, 5'd2, 16'h0000, 16'h0000, 16'h0007};
    vecs[14] = '{WR, 5'd1, 5'd5, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[15] = '{RD, 5'd1, 5'd5, 16'h0000, 16'h0000, 16'hBEEF};
    vecs[16] = '{WR, 5'd1, 5'd0, 16'h1140, 16'h0000, 16'h0000};
    vecs[17] = '{RD, 5'd1, 5'd0, 16'h0000, 16'h0000, 16'h1140};

    repeat (5) @(negedge Clk);
    check("rst MDIO_Oe", {31'd0, MDIO_Oe}, 32'd0);
    check("rst MDIO_O", {31'd0, MDIO_O}, 32'd0);
    check("rst Busy", {31'd0, Busy}, 32'd0);
    check("rst strobes", {29'd0, Wr_Strb, Rd_Strb, Frame_Err}, 32'd0);
    check("rst Wr_Addr", {27'd0, Wr_Addr}, 32'd0);
    check("rst Wr_Data", {16'd0, Wr_Data}, 32'd0);
    check("rst Reg0_Ctrl", {16'd0, Reg0_Ctrl}, 32'h3100);
    Rst = 1'b0;
    repeat (4) @(negedge Clk);

    for (int i = 0; i < 18; i++) begin
      is_rd = (vecs[i].op == RD);
      hit = (vecs[i].pa == 5'd1);
      Status_In = vecs[i].status;
      run_check($sformatf("v%0d", i), 32, vecs[i].op, vecs[i].pa, vecs[i].ra, vecs[i].wd,
                (is_rd && hit) ? 17 : 0, is_rd ? 0 : 1, (is_rd && hit) ? 1 : 0, 0, 1,
                is_rd, vecs[i].exp_rd);
      $display("[TB] v%0d op=%b pa=%0d ra=%0d wd=%h exp=%h", i, vecs[i].op, vecs[i].pa,
               vecs[i].ra, vecs[i].wd, vecs[i].exp_rd);
    end
    check("reg0_ctrl_after_write", {16'd0, Reg0_Ctrl}, 32'h1140);
    check("wr_addr_hold", {27'd0, Wr_Addr}, 32'd0);
    check("wr_data_hold", {16'd0, Wr_Data}, 32'h1140);

    // 31 preamble ones: never synchronises, so no busy, drive or error.
    run_check("short_pre", 31, RD, 5'd1, 5'd0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000);
    $display("[TB] short preamble read");
    // OP=11 after a full preamble: error pulse, busy through the frame, no drive.
    run_check("op11", 32, 2'b11, 5'd1, 5'd0, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000);
    $display("[TB] op=11 frame");

    // Reset during D7 of a read (bit index 16 + 8).
    frame(32, RD, 5'd1, 5'd5, 16'h0000, 24, rd, oe_cnt, ta2);
    $display("[TB] read reg5 aborted by reset at D7");
    check("post_rst reg0_ctrl", {16'd0, Reg0_Ctrl}, 32'h3100);
    run_check("post_rst_r0", 32, RD, 5'd1, 5'd0, 16'h0000, 17, 0, 1, 0, 1, 1, 16'h3100);
    $display("[TB] read reg0 after reset");
    run_check("post_rst_r5", 32, RD, 5'd1, 5'd5, 16'h0000, 17, 0, 1, 0, 1, 1, 16'h0000);
    $display("[TB] read reg5 after reset");
    check("spurious_writes", obs_wr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
